// File: rtl/simd_wbq_defs.sv
`default_nettype none
// ============================================================================
// Module   : simd_wbq_defs (package)
// Brief    : Field widths, entry layout and default sizing for the SIMD
//            writeback queue.
// Revision : 1.0 - initial release
// ============================================================================
package simd_wbq_defs;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 2048;
    localparam int MASK_W  = 64;
    localparam int WFID_W  = 6;
    localparam int PC_W    = 32;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W + MASK_W + WFID_W + PC_W;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_SKID  = 2;

    // One completed SIMD instruction as held in the queue.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] mask;
        logic [WFID_W-1:0] wfid;
        logic [PC_W-1:0]   pc;
    } wbq_entry_t;

endpackage
`default_nettype wire

// File: rtl/simd_wbq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : simd_wbq_fifo
// Brief    : Register-array FIFO with head read, occupancy and full/empty.
//            Pushes while full are dropped unless a pop frees a slot in the
//            same cycle; pops while empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module simd_wbq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     count_nxt,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign rdata     = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign count_nxt = count_d;

    // Accept/retire qualification and next pointer/occupancy values.
    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless until a push lands.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/simd_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : simd_wb_queue
// Brief    : In-order writeback queue between SIMD ALU results and the VGPR
//            write port. Write entries wait for an RFA grant, non-write
//            entries retire on their own; retirement is strictly FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module simd_wb_queue
    import simd_wbq_defs::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int SKID  = DEFAULT_SKID
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vgpr_wr_en,
    input  logic [ADDR_W-1:0]        in_vgpr_dest_addr,
    input  logic [DATA_W-1:0]        in_vgpr_dest_data,
    input  logic [MASK_W-1:0]        in_vgpr_wr_mask,
    input  logic                     in_instr_done,
    input  logic [WFID_W-1:0]        in_instr_done_wfid,
    input  logic [PC_W-1:0]          in_retire_pc,
    input  logic                     rfa_queue_entry_serviced,
    output logic                     rfa_queue_entry_valid,
    output logic                     vgpr_wr_en,
    output logic [ADDR_W-1:0]        vgpr_dest_addr,
    output logic [DATA_W-1:0]        vgpr_dest_data,
    output logic [MASK_W-1:0]        vgpr_wr_mask,
    output logic                     vgpr_instr_done,
    output logic [WFID_W-1:0]        vgpr_instr_done_wfid,
    output logic [PC_W-1:0]          tracemon_retire_pc,
    output logic                     wbq_ready,
    output logic [$clog2(DEPTH):0]   wbq_count,
    output logic                     wbq_overflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - SKID);

    wbq_entry_t    in_entry;
    wbq_entry_t    head;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] fifo_count_nxt;

    wbq_entry_t    retire_q, retire_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic          overflow_q, overflow_d;

    // Pack the ALU result into a queue entry.
    always_comb begin
        in_entry.wr   = in_vgpr_wr_en;
        in_entry.addr = in_vgpr_dest_addr;
        in_entry.data = in_vgpr_dest_data;
        in_entry.mask = in_vgpr_wr_mask;
        in_entry.wfid = in_instr_done_wfid;
        in_entry.pc   = in_retire_pc;
    end

    simd_wbq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wdata     (in_entry),
        .rdata     (head),
        .count     (fifo_count),
        .count_nxt (fifo_count_nxt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head classification: writes wait for a grant, non-writes leave at once.
    // Only registered head state feeds the request so it never sees in_*.
    always_comb begin
        push                  = in_instr_done | in_vgpr_wr_en;
        rfa_queue_entry_valid = ~fifo_empty & head.wr;
        pop                   = ~fifo_empty & (~head.wr | rfa_queue_entry_serviced);
    end

    // Next retire outputs, ready level and sticky overflow.
    always_comb begin
        retire_d    = retire_q;
        retire_d.wr = 1'b0;
        done_d      = 1'b0;
        if (pop) begin
            retire_d = head;
            done_d   = 1'b1;
        end
        ready_d    = (fifo_count_nxt <= READY_MAX);
        overflow_d = overflow_q | (push & fifo_full & ~pop);
    end

    // Retire, ready and overflow registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_q   <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            retire_q   <= retire_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
        end
    end

    assign vgpr_wr_en           = retire_q.wr;
    assign vgpr_dest_addr       = retire_q.addr;
    assign vgpr_dest_data       = retire_q.data;
    assign vgpr_wr_mask         = retire_q.mask;
    assign vgpr_instr_done      = done_q;
    assign vgpr_instr_done_wfid = retire_q.wfid;
    assign tracemon_retire_pc   = retire_q.pc;
    assign wbq_ready            = ready_q;
    assign wbq_count            = fifo_count;
    assign wbq_overflow         = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_simd_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_simd_wb_queue
// Brief    : Self-checking bench for simd_wb_queue with a retire scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simd_wb_queue;
    import simd_wbq_defs::*;

    localparam int DEPTH = 4;
    localparam int SKID  = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_vgpr_wr_en;
    logic [ADDR_W-1:0] in_vgpr_dest_addr;
    logic [DATA_W-1:0] in_vgpr_dest_data;
    logic [MASK_W-1:0] in_vgpr_wr_mask;
    logic              in_instr_done;
    logic [WFID_W-1:0] in_instr_done_wfid;
    logic [PC_W-1:0]   in_retire_pc;
    logic              rfa_queue_entry_serviced;
    logic              rfa_queue_entry_valid;
    logic              vgpr_wr_en;
    logic [ADDR_W-1:0] vgpr_dest_addr;
    logic [DATA_W-1:0] vgpr_dest_data;
    logic [MASK_W-1:0] vgpr_wr_mask;
    logic              vgpr_instr_done;
    logic [WFID_W-1:0] vgpr_instr_done_wfid;
    logic [PC_W-1:0]   tracemon_retire_pc;
    logic              wbq_ready;
    logic [CW-1:0]     wbq_count;
    logic              wbq_overflow;

    wbq_entry_t sb[$];
    int checks = 0;
    int errors = 0;

    simd_wb_queue #(.DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .in_vgpr_wr_en            (in_vgpr_wr_en),
        .in_vgpr_dest_addr        (in_vgpr_dest_addr),
        .in_vgpr_dest_data        (in_vgpr_dest_data),
        .in_vgpr_wr_mask          (in_vgpr_wr_mask),
        .in_instr_done            (in_instr_done),
        .in_instr_done_wfid       (in_instr_done_wfid),
        .in_retire_pc             (in_retire_pc),
        .rfa_queue_entry_serviced (rfa_queue_entry_serviced),
        .rfa_queue_entry_valid    (rfa_queue_entry_valid),
        .vgpr_wr_en               (vgpr_wr_en),
        .vgpr_dest_addr           (vgpr_dest_addr),
        .vgpr_dest_data           (vgpr_dest_data),
        .vgpr_wr_mask             (vgpr_wr_mask),
        .vgpr_instr_done          (vgpr_instr_done),
        .vgpr_instr_done_wfid     (vgpr_instr_done_wfid),
        .tracemon_retire_pc       (tracemon_retire_pc),
        .wbq_ready                (wbq_ready),
        .wbq_count                (wbq_count),
        .wbq_overflow             (wbq_overflow)
    );

    always #5 clk = ~clk;

    function automatic wbq_entry_t mk(input logic wr, input logic [31:0] pc);
        wbq_entry_t e;
        e.wr   = wr;
        e.pc   = pc;
        e.addr = pc[9:0] ^ 10'h2A5;
        e.wfid = pc[7:2];
        e.mask = {32'($urandom), 32'($urandom)};
        for (int i = 0; i < 64; i++) e.data[i*32 +: 32] = 32'($urandom);
        return e;
    endfunction

    task automatic idle_in();
        in_vgpr_wr_en = 1'b0;
        in_instr_done = 1'b0;
    endtask

    task automatic drive_entry(input wbq_entry_t e, input bit accept);
        in_vgpr_wr_en      = e.wr;
        in_instr_done      = 1'b1;
        in_vgpr_dest_addr  = e.addr;
        in_vgpr_dest_data  = e.data;
        in_vgpr_wr_mask    = e.mask;
        in_instr_done_wfid = e.wfid;
        in_retire_pc       = e.pc;
        if (accept) sb.push_back(e);
    endtask

    // Advance one clock; any retire pulse is compared with the oldest expected entry.
    task automatic tick();
        wbq_entry_t exp;
        @(posedge clk);
        #1;
        if (vgpr_instr_done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected: got retire pc=%h, required no retire", tracemon_retire_pc);
            end else begin
                exp = sb.pop_front();
                if (vgpr_wr_en !== exp.wr || vgpr_dest_addr !== exp.addr || vgpr_dest_data !== exp.data ||
                    vgpr_wr_mask !== exp.mask || vgpr_instr_done_wfid !== exp.wfid || tracemon_retire_pc !== exp.pc) begin
                    errors++;
                    $display("FAIL retire_fields: got wr=%b addr=%h mask=%h wfid=%0d pc=%h data_ok=%b, required wr=%b addr=%h mask=%h wfid=%0d pc=%h",
                             vgpr_wr_en, vgpr_dest_addr, vgpr_wr_mask, vgpr_instr_done_wfid, tracemon_retire_pc,
                             vgpr_dest_data === exp.data, exp.wr, exp.addr, exp.mask, exp.wfid, exp.pc);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rfa_queue_entry_serviced = 1'b0;
        in_vgpr_dest_addr = '0; in_vgpr_dest_data = '0; in_vgpr_wr_mask = '0;
        in_instr_done_wfid = '0; in_retire_pc = '0;
        idle_in();
        @(posedge clk);
        #1;
        checks++;
        if ({vgpr_wr_en, vgpr_instr_done, rfa_queue_entry_valid, wbq_overflow} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes: got wr=%b done=%b valid=%b ovf=%b, required all 0",
                     vgpr_wr_en, vgpr_instr_done, rfa_queue_entry_valid, wbq_overflow);
        end
        checks++;
        if (vgpr_dest_addr !== '0 || vgpr_dest_data !== '0 || vgpr_wr_mask !== '0 ||
            vgpr_instr_done_wfid !== '0 || tracemon_retire_pc !== '0) begin
            errors++;
            $display("FAIL reset_fields: got addr=%h pc=%h wfid=%0d, required all 0",
                     vgpr_dest_addr, tracemon_retire_pc, vgpr_instr_done_wfid);
        end
        checks++;
        if (wbq_ready !== 1'b1 || wbq_count !== '0) begin
            errors++;
            $display("FAIL reset_ready_count: got ready=%b count=%0d, required ready=1 count=0", wbq_ready, wbq_count);
        end
        #2 rst = 1'b1;
        tick();
        checks++;
        if (wbq_ready !== 1'b1 || wbq_count !== '0 || rfa_queue_entry_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got ready=%b count=%0d valid=%b, required 1 0 0",
                     wbq_ready, wbq_count, rfa_queue_entry_valid);
        end
    endtask

    task automatic test_single_write();
        wbq_entry_t e;
        e = mk(1'b1, 32'h100);
        e.addr = 10'h01A;
        e.mask = '1;
        e.data[31:0] = 32'hDEADBEEF;
        e.wfid = 6'd5;
        drive_entry(e, 1'b1);
        tick();
        idle_in();
        checks++;
        if (rfa_queue_entry_valid !== 1'b1 || wbq_count !== CW'(1)) begin
            errors++;
            $display("FAIL single_valid_t1: got valid=%b count=%0d, required valid=1 count=1", rfa_queue_entry_valid, wbq_count);
        end
        tick();
        tick();
        checks++;
        if (rfa_queue_entry_valid !== 1'b1 || vgpr_instr_done !== 1'b0) begin
            errors++;
            $display("FAIL single_wait: got valid=%b done=%b, required valid=1 done=0", rfa_queue_entry_valid, vgpr_instr_done);
        end
        rfa_queue_entry_serviced = 1'b1;
        tick();
        rfa_queue_entry_serviced = 1'b0;
        checks++;
        if (vgpr_wr_en !== 1'b1 || vgpr_dest_addr !== 10'h01A || tracemon_retire_pc !== 32'h100) begin
            errors++;
            $display("FAIL single_retire: got wr=%b addr=%h pc=%h, required wr=1 addr=01a pc=00000100",
                     vgpr_wr_en, vgpr_dest_addr, tracemon_retire_pc);
        end
        tick();
        checks++;
        if (vgpr_wr_en !== 1'b0 || vgpr_instr_done !== 1'b0 || rfa_queue_entry_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL single_one_cycle: got wr=%b done=%b valid=%b pending=%0d, required 0 0 0 0",
                     vgpr_wr_en, vgpr_instr_done, rfa_queue_entry_valid, sb.size());
        end
    endtask

    task automatic test_mixed_order();
        logic [31:0] pcs [3];
        logic        wrs [3];
        pcs[0] = 32'h10; pcs[1] = 32'h14; pcs[2] = 32'h18;
        wrs[0] = 1'b1;   wrs[1] = 1'b0;   wrs[2] = 1'b1;
        rfa_queue_entry_serviced = 1'b1;
        drive_entry(mk(wrs[0], pcs[0]), 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive_entry(mk(wrs[i+1], pcs[i+1]), 1'b1);
            else idle_in();
            tick();
            checks++;
            if (vgpr_instr_done !== 1'b1 || vgpr_wr_en !== wrs[i] || tracemon_retire_pc !== pcs[i]) begin
                errors++;
                $display("FAIL mixed_order[%0d]: got done=%b wr=%b pc=%h, required done=1 wr=%b pc=%h",
                         i, vgpr_instr_done, vgpr_wr_en, tracemon_retire_pc, wrs[i], pcs[i]);
            end
        end
        rfa_queue_entry_serviced = 1'b0;
        tick();
        checks++;
        if (vgpr_instr_done !== 1'b0 || wbq_count !== '0) begin
            errors++;
            $display("FAIL mixed_drained: got done=%b count=%0d, required 0 0", vgpr_instr_done, wbq_count);
        end
    endtask

    task automatic test_backpressure_full();
        rfa_queue_entry_serviced = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_entry(mk(1'b1, 32'h40 + 32'(4*i)), 1'b1);
            tick();
            if (i == 1) begin
                checks++;
                if (wbq_ready !== 1'b1 || wbq_count !== CW'(2)) begin
                    errors++;
                    $display("FAIL ready_at_limit: got ready=%b count=%0d, required ready=1 count=2", wbq_ready, wbq_count);
                end
            end
        end
        checks++;
        if (wbq_ready !== 1'b0 || wbq_count !== CW'(3)) begin
            errors++;
            $display("FAIL ready_drop: got ready=%b count=%0d, required ready=0 count=3", wbq_ready, wbq_count);
        end
        drive_entry(mk(1'b1, 32'h4C), 1'b1);
        tick();
        checks++;
        if (wbq_count !== CW'(4) || wbq_overflow !== 1'b0 || wbq_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_to_depth: got count=%0d ovf=%b ready=%b, required 4 0 0", wbq_count, wbq_overflow, wbq_ready);
        end
        // Push and grant together while full.
        drive_entry(mk(1'b1, 32'h200), 1'b1);
        rfa_queue_entry_serviced = 1'b1;
        tick();
        rfa_queue_entry_serviced = 1'b0;
        checks++;
        if (wbq_count !== CW'(4) || wbq_overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: got count=%0d ovf=%b, required count=4 ovf=0", wbq_count, wbq_overflow);
        end
        // Push while full with no grant is dropped.
        drive_entry(mk(1'b1, 32'h300), 1'b0);
        tick();
        idle_in();
        checks++;
        if (wbq_count !== CW'(4) || wbq_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow: got count=%0d ovf=%b, required count=4 ovf=1", wbq_count, wbq_overflow);
        end
        rfa_queue_entry_serviced = 1'b1;
        for (int i = 0; i < 20 && wbq_count != '0; i++) tick();
        rfa_queue_entry_serviced = 1'b0;
        checks++;
        if (wbq_count !== '0 || sb.size() != 0 || wbq_ready !== 1'b1 || wbq_overflow !== 1'b1) begin
            errors++;
            $display("FAIL drain: got count=%0d pending=%0d ready=%b ovf=%b, required 0 0 1 1",
                     wbq_count, sb.size(), wbq_ready, wbq_overflow);
        end
        tick();
    endtask

    task automatic test_spurious_grant();
        idle_in();
        rfa_queue_entry_serviced = 1'b1;
        tick();
        rfa_queue_entry_serviced = 1'b0;
        tick();
        checks++;
        if (vgpr_instr_done !== 1'b0 || wbq_count !== '0 || rfa_queue_entry_valid !== 1'b0) begin
            errors++;
            $display("FAIL spurious_grant: got done=%b count=%0d valid=%b, required 0 0 0",
                     vgpr_instr_done, wbq_count, rfa_queue_entry_valid);
        end
    endtask

    task automatic test_reset_midflight();
        rfa_queue_entry_serviced = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_entry(mk(1'b1, 32'h500 + 32'(4*i)), 1'b1);
            tick();
        end
        idle_in();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        sb.delete();
        checks++;
        if ({vgpr_wr_en, vgpr_instr_done, rfa_queue_entry_valid, wbq_overflow} !== 4'b0 ||
            vgpr_dest_addr !== '0 || vgpr_dest_data !== '0 || vgpr_wr_mask !== '0 ||
            vgpr_instr_done_wfid !== '0 || tracemon_retire_pc !== '0) begin
            errors++;
            $display("FAIL midflight_outputs: got valid=%b ovf=%b addr=%h pc=%h, required all 0",
                     rfa_queue_entry_valid, wbq_overflow, vgpr_dest_addr, tracemon_retire_pc);
        end
        checks++;
        if (wbq_ready !== 1'b1 || wbq_count !== '0) begin
            errors++;
            $display("FAIL midflight_ready: got ready=%b count=%0d, required ready=1 count=0", wbq_ready, wbq_count);
        end
        #2 rst = 1'b1;
        rfa_queue_entry_serviced = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (vgpr_instr_done !== 1'b0 || wbq_count !== '0) begin
                errors++;
                $display("FAIL after_reset_quiet[%0d]: got done=%b count=%0d, required 0 0", i, vgpr_instr_done, wbq_count);
            end
        end
        rfa_queue_entry_serviced = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_mixed_order();
        test_backpressure_full();
        test_spurious_grant();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
